merge: RTL and testbench
========================

Name: merge

Overview:
- Many-to-one bus merger: N_MASTERS native-bus masters share a single slave port.
- The inverse of the address-split fabric: fans in where split fans out.
- Round-robin arbitration; grant locked from acceptance until the slave's ready.
- Sits in front of shared slaves, e.g. the I- and D-ports of the CPU converging on one memory.

Parameters:
- TYPE, `D, bus flavour: `I = {valid, addr}; `D = {valid, addr, wdata[31:0], wstrb[3:0]}.
- N_MASTERS, 2, number of master ports (>=2).
- ADDR_W, 32, address width, identical on master and slave sides.
- TIMEOUT_CYC, 255, slave-response timeout in cycles; used only with MERGE_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- m_req  input  N_MASTERS*BUS_REQ_W(TYPE,ADDR_W)  concatenated master requests; master 0 in the LSB slice, valid is the MSB of each slice.
- m_resp  output  N_MASTERS*BUS_RESP_W  concatenated master responses, each {rdata[31:0], ready}.
- s_req  output  BUS_REQ_W(TYPE,ADDR_W)  request to the shared slave.
- s_resp  input  BUS_RESP_W  slave response {rdata, ready}.
- s_id  output  max(1,$clog2(N_MASTERS))  index of the currently granted master.

Behaviour:
- Protocol: a master holds valid and its request fields stable until it sees ready. Ready is a one-cycle pulse.
- FSM states:
  - IDLE: s_req is all zeros.
  - BUSY: s_req is the granted master's m_req slice.
- IDLE -> BUSY:
  - Triggered when any master valid is sampled high.
  - Winner = first valid master at or after the priority pointer, searching upward and wrapping modulo N_MASTERS.
  - grant and s_id are registered, so s_req shows the winner's request on the cycle after its valid was sampled: 1 cycle of added request latency.
- In BUSY, the response is combinational: m_resp[grant] = s_resp; all other m_resp slices = 0.
- BUSY -> IDLE:
  - Triggered on s_resp.ready=1.
  - The same cycle, the priority pointer becomes (grant+1) mod N_MASTERS.
  - No re-arbitration in that cycle. The next grant is issued on the following edge at the earliest, so back-to-back transactions cost one bubble cycle.
- Simultaneous valids: the pointer decides. Non-winners wait; their ready stays 0.
- A valid that drops while its master is granted is a protocol violation. The block stays in BUSY until ready and is not required to recover earlier.
- Ready while IDLE is ignored; no m_resp ready is generated.
- Reset values (any time, including mid-transaction): state = IDLE, pointer = 0, grant/s_id = 0, s_req = 0, all m_resp = 0. An in-flight slave response after reset is dropped.
- N_MASTERS not a power of two: the pointer wraps at N_MASTERS-1 -> 0, never to an unused index.

Optional Feature:
- Macro: MERGE_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without ready.
  - When it reaches TIMEOUT_CYC, the block forces m_resp[grant] = {32'hDEADBEEF, 1'b1} for one cycle.
  - It drives s_req = 0 that cycle, returns to IDLE and advances the pointer.
  - A late slave ready then arrives while IDLE and is ignored.
- When undefined: no counter, and BUSY waits indefinitely.

Decomposition:
- Shared header interconnect.vh holds:
  - the `I/`D type constants;
  - the BUS_REQ_W/BUS_RESP_W width macros;
  - the valid/addr/wdata/wstrb/rdata/ready field-offset macros;
  - the 0xDEADBEEF timeout data constant.
- Sub-module merge_rr_arbiter (N parameter):
  - inputs: the N-bit request vector and the pointer;
  - outputs: one-hot grant and encoded index;
  - purely combinational priority search.
- The FSM, registers and muxing live in merge.

Test Plan:
- N=2, master 0 valid, addr=0x10, wdata=0x11223344, wstrb=0xF; slave ready after 3 cycles with rdata=0 -> s_req equals m0 slice one cycle after valid, s_id=0, m0 ready pulses once, m1 ready stays 0.
- Both masters valid in the same cycle after reset -> m0 served first, then pointer=1, then m1 served. Repeated contention alternates 0,1,0,1.
- N=3, master 2 the only requester, pointer=0 -> grant=2; after ready the pointer wraps to 0.
- rst asserted during BUSY while the slave is waiting -> the same-cycle asynchronous clear sets s_req=0, m_resp=0 and state IDLE; a later slave ready is ignored.
- MERGE_TIMEOUT_EN, TIMEOUT_CYC=8, slave never readies -> after 8 BUSY cycles the granted master gets ready=1 with rdata=0xDEADBEEF, and the next requester is granted.
- TYPE=`I, ADDR_W=16 -> s_req width 17 and slice routing is correct; wdata/wstrb are absent.

Source files
------------

// File: rtl/merge_pkg.sv
// merge_pkg: bus flavour constants, request/response widths, timeout data and FSM state type for merge
package merge_pkg;
  localparam int TYPE_I = 0;
  localparam int TYPE_D = 1;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int BUS_RESP_W = DATA_W + 1;
  localparam int RESP_READY = 0;
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEADBEEF;
  typedef enum logic {IDLE, BUSY} state_t;
  function automatic int bus_req_w(input int t, input int aw);
    return t == TYPE_I ? aw + 1 : aw + DATA_W + STRB_W + 1;
  endfunction
  function automatic int id_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/merge_if.sv
// merge_if: master-side request/response vectors plus shared slave port of the merge block
interface merge_if
  import merge_pkg::*;
#(
  parameter int TYPE = TYPE_D,
  parameter int N_MASTERS = 2,
  parameter int ADDR_W = 32
);
  localparam int RW = bus_req_w(TYPE, ADDR_W);
  localparam int IW = id_w(N_MASTERS);
  logic [N_MASTERS*RW-1:0] m_req;
  logic [N_MASTERS*BUS_RESP_W-1:0] m_resp;
  logic [RW-1:0] s_req;
  logic [BUS_RESP_W-1:0] s_resp;
  logic [IW-1:0] s_id;
  modport slave (input m_req, s_resp, output m_resp, s_req, s_id);
  modport master (output m_req, s_resp, input m_resp, s_req, s_id);
endinterface

// File: rtl/merge_rr_arbiter.sv
// merge_rr_arbiter: combinational round-robin search from ptr upward, wrapping at N-1
module merge_rr_arbiter #(
  parameter int N = 2,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW:0] j;
  // scan from farthest to nearest offset so the nearest requester at or after ptr wins
  always_comb begin
    gnt = '0;
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = {1'b0, ptr} + (IW + 1)'(k);
      j = j >= (IW + 1)'(N) ? j - (IW + 1)'(N) : j;
      if (req[j[IW-1:0]]) begin
        idx = j[IW-1:0];
        gnt = '0;
        gnt[j[IW-1:0]] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/merge.sv
// merge: round-robin many-to-one bus merger; define MERGE_TIMEOUT_EN to add a slave-response timeout
module merge
  import merge_pkg::*;
#(
  parameter int TYPE = TYPE_D,
  parameter int N_MASTERS = 2,
  parameter int ADDR_W = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input logic clk,
  input logic rst,
  merge_if.slave bus
);
  localparam int RW = bus_req_w(TYPE, ADDR_W);
  localparam int IW = id_w(N_MASTERS);
  state_t state, state_nx;
  logic [IW-1:0] grant, grant_nx, ptr, ptr_nx, win;
  logic [N_MASTERS-1:0] valid, win_oh;
  logic [RW-1:0] req_arr [N_MASTERS];
  logic [BUS_RESP_W-1:0] resp;
  logic timeout, done;
  if (N_MASTERS < 2 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("merge: N_MASTERS must be >= 2 and TIMEOUT_CYC >= 1");
  end
  for (genvar i = 0; i < N_MASTERS; i++) begin : g_slice
    assign req_arr[i] = bus.m_req[i*RW +: RW];
    assign valid[i] = req_arr[i][RW-1];
    assign bus.m_resp[i*BUS_RESP_W +: BUS_RESP_W] = state == BUSY && grant == IW'(i) ? resp : '0;
  end
  merge_rr_arbiter #(.N(N_MASTERS)) u_arb (.req(valid), .ptr(ptr), .gnt(win_oh), .idx(win));
`ifdef MERGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  // counts BUSY cycles; held at zero while idle so every grant starts from zero
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= state == BUSY ? cnt + 1'b1 : '0;
  assign timeout = state == BUSY && cnt == CW'(TIMEOUT_CYC);
`else
  assign timeout = 1'b0;
`endif
  assign resp = timeout ? {TIMEOUT_DATA, 1'b1} : bus.s_resp;
  assign done = bus.s_resp[RESP_READY] || timeout;
  assign bus.s_req = state == BUSY && !timeout ? req_arr[grant] : '0;
  assign bus.s_id = grant;
  // grant, pointer and state registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      ptr <= '0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      ptr <= ptr_nx;
    end
  // arbitrate only from IDLE; a finished grant always returns to IDLE, giving one bubble cycle
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    ptr_nx = ptr;
    if (state == IDLE && |win_oh) begin
      state_nx = BUSY;
      grant_nx = win;
    end else if (state == BUSY && done) begin
      state_nx = IDLE;
      ptr_nx = grant == IW'(N_MASTERS - 1) ? '0 : grant + 1'b1;
    end
  end
endmodule

// File: tb/tb_merge.sv
// tb_merge: table-driven, directed and randomized checks of merge on a 2-master D bus and a 3-master I bus
module tb_merge;
  import merge_pkg::*;
  localparam int RA = 69;
  localparam int RB = 17;
  localparam int RS = BUS_RESP_W;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [RA-1:0] ra [2];
  logic [RB-1:0] rb [3];
  typedef struct {logic [1:0] mask; int n; int first; int second; int dly;} vec_t;
  vec_t tbl [8];
  always #5 clk = ~clk;
  merge_if #(.TYPE(TYPE_D), .N_MASTERS(2), .ADDR_W(32)) bus_a ();
  merge_if #(.TYPE(TYPE_I), .N_MASTERS(3), .ADDR_W(16)) bus_b ();
  merge #(.TYPE(TYPE_D), .N_MASTERS(2), .ADDR_W(32), .TIMEOUT_CYC(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  merge #(.TYPE(TYPE_I), .N_MASTERS(3), .ADDR_W(16), .TIMEOUT_CYC(8)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RA-1:0] rnd_a();
    return {1'b1, $urandom, $urandom, 4'($urandom)};
  endfunction

  function automatic logic [RB-1:0] rnd_b();
    return {1'b1, 16'($urandom)};
  endfunction

  task automatic serve_a(input int g, input int dly);
    logic [31:0] rd;
    logic [2*RS-1:0] e;
    step();
    #1;
    chk("a_grant_id", 128'(bus_a.s_id), 128'(g));
    chk("a_grant_req", 128'(bus_a.s_req), 128'(ra[g]));
    repeat (dly) begin
      step();
      #1;
      chk("a_wait_resp", 128'(bus_a.m_resp), 128'(0));
      chk("a_wait_req", 128'(bus_a.s_req), 128'(ra[g]));
    end
    step();
    rd = $urandom;
    bus_a.s_resp = {rd, 1'b1};
    #1;
    e = '0;
    e[g*RS +: RS] = {rd, 1'b1};
    chk("a_resp", 128'(bus_a.m_resp), 128'(e));
    step();
    bus_a.s_resp = '0;
    bus_a.m_req[g*RA +: RA] = '0;
    #1;
    chk("a_bubble", 128'(bus_a.s_req), 128'(0));
  endtask

  task automatic serve_b(input int g, input int dly);
    logic [31:0] rd;
    logic [3*RS-1:0] e;
    step();
    #1;
    chk("b_grant_id", 128'(bus_b.s_id), 128'(g));
    chk("b_grant_req", 128'(bus_b.s_req), 128'(rb[g]));
    repeat (dly) begin
      step();
      #1;
      chk("b_wait_resp", 128'(bus_b.m_resp), 128'(0));
    end
    step();
    rd = $urandom;
    bus_b.s_resp = {rd, 1'b1};
    #1;
    e = '0;
    e[g*RS +: RS] = {rd, 1'b1};
    chk("b_resp", 128'(bus_b.m_resp), 128'(e));
    step();
    bus_b.s_resp = '0;
    bus_b.m_req[g*RB +: RB] = '0;
    #1;
    chk("b_bubble", 128'(bus_b.s_req), 128'(0));
  endtask

  task automatic reset_mid_busy();
    ra[1] = rnd_a();
    bus_a.m_req[RA +: RA] = ra[1];
    step();
    #1;
    chk("rst_pre_id", 128'(bus_a.s_id), 128'(1));
    step();
    step();
    #2;
    rst = 1'b1;
    bus_a.s_resp = {32'h12345678, 1'b1};
    #1;
    chk("rst_sreq", 128'(bus_a.s_req), 128'(0));
    chk("rst_mresp", 128'(bus_a.m_resp), 128'(0));
    chk("rst_sid", 128'(bus_a.s_id), 128'(0));
    step();
    rst = 1'b0;
    bus_a.m_req = '0;
    #1;
    chk("late_ready_idle", 128'(bus_a.m_resp), 128'(0));
    step();
    bus_a.s_resp = '0;
    ra[0] = rnd_a();
    ra[1] = rnd_a();
    bus_a.m_req = {ra[1], ra[0]};
    serve_a(0, 1);
    serve_a(1, 0);
  endtask

  task automatic timeout_test();
    logic [2*RS-1:0] e;
    ra[0] = rnd_a();
    bus_a.m_req[0 +: RA] = ra[0];
    step();
    #1;
    chk("to_id", 128'(bus_a.s_id), 128'(0));
    repeat (7) begin
      step();
      #1;
      chk("to_wait", 128'(bus_a.m_resp), 128'(0));
    end
    step();
    #1;
    e = '0;
    e[0 +: RS] = {32'hDEADBEEF, 1'b1};
    chk("to_resp", 128'(bus_a.m_resp), 128'(e));
    chk("to_sreq", 128'(bus_a.s_req), 128'(0));
    step();
    bus_a.m_req = '0;
    bus_a.s_resp = {32'h55AA55AA, 1'b1};
    #1;
    chk("to_late_ready", 128'(bus_a.m_resp), 128'(0));
    #1;
    bus_a.s_resp = '0;
    ra[0] = rnd_a();
    ra[1] = rnd_a();
    bus_a.m_req = {ra[1], ra[0]};
    serve_a(1, 0);
    serve_a(0, 0);
  endtask

  task automatic random_a();
    logic [1:0] v = '0;
    logic [1:0] done = '0;
    logic busy_m = 1'b0;
    logic found;
    int ptr_m = 0;
    int grant_m = 0;
    int wl = -1;
    int j;
    logic [2*RS-1:0] e;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (v[i] && done[i]) begin
          v[i] = 1'b0;
          bus_a.m_req[i*RA +: RA] = '0;
        end
        if (!v[i] && $urandom_range(0, 1) == 0) begin
          v[i] = 1'b1;
          ra[i] = rnd_a();
          bus_a.m_req[i*RA +: RA] = ra[i];
        end
      end
      bus_a.s_resp = '0;
      if (bus_a.s_req[RA-1]) begin
        if (wl < 0) wl = $urandom_range(0, 3);
        if (wl == 0) begin
          bus_a.s_resp = {$urandom, 1'b1};
          wl = -1;
        end else wl--;
      end
      #1;
      e = '0;
      if (busy_m) e[grant_m*RS +: RS] = bus_a.s_resp;
      chk("rnd_sreq", 128'(bus_a.s_req), busy_m ? 128'(ra[grant_m]) : 128'(0));
      chk("rnd_sid", 128'(bus_a.s_id), 128'(grant_m));
      chk("rnd_mresp", 128'(bus_a.m_resp), 128'(e));
      if (busy_m) begin
        if (bus_a.s_resp[0]) begin
          busy_m = 1'b0;
          ptr_m = (grant_m + 1) % 2;
        end
      end else begin
        found = 1'b0;
        for (int k = 0; k < 2; k++) begin
          j = (ptr_m + k) % 2;
          if (!found && v[j]) begin
            found = 1'b1;
            grant_m = j;
            busy_m = 1'b1;
          end
        end
      end
      done = {bus_a.m_resp[RS], bus_a.m_resp[0]};
      step();
    end
    bus_a.m_req = '0;
    bus_a.s_resp = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_b();
    rb[2] = rnd_b();
    bus_b.m_req[2*RB +: RB] = rb[2];
    serve_b(2, 1);
    for (int i = 0; i < 3; i++) begin
      rb[i] = rnd_b();
      bus_b.m_req[i*RB +: RB] = rb[i];
    end
    serve_b(0, 0);
    serve_b(1, 2);
    serve_b(2, 0);
    rb[1] = rnd_b();
    rb[2] = rnd_b();
    bus_b.m_req[RB +: 2*RB] = {rb[2], rb[1]};
    serve_b(1, 0);
    serve_b(2, 1);
  endtask

  initial begin
    tbl[0] = '{2'b01, 1, 0, 0, 3};
    tbl[1] = '{2'b11, 2, 1, 0, 0};
    tbl[2] = '{2'b11, 2, 1, 0, 1};
    tbl[3] = '{2'b10, 1, 1, 0, 2};
    tbl[4] = '{2'b11, 2, 0, 1, 0};
    tbl[5] = '{2'b10, 1, 1, 0, 1};
    tbl[6] = '{2'b01, 1, 0, 0, 0};
    tbl[7] = '{2'b01, 1, 0, 0, 2};
    rst = 1'b1;
    bus_a.m_req = '0;
    bus_b.m_req = '0;
    bus_a.s_resp = {32'hCAFEF00D, 1'b1};
    bus_b.s_resp = {32'hCAFEF00D, 1'b1};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a_sreq", 128'(bus_a.s_req), 128'(0));
    chk("reset_a_mresp", 128'(bus_a.m_resp), 128'(0));
    chk("reset_a_sid", 128'(bus_a.s_id), 128'(0));
    chk("reset_b_sreq", 128'(bus_b.s_req), 128'(0));
    chk("reset_b_mresp", 128'(bus_b.m_resp), 128'(0));
    step();
    rst = 1'b0;
    #1;
    chk("idle_ready_a", 128'(bus_a.m_resp), 128'(0));
    chk("idle_ready_b", 128'(bus_b.m_resp), 128'(0));
    step();
    bus_a.s_resp = '0;
    bus_b.s_resp = '0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 2; i++)
        if (tbl[k].mask[i]) begin
          ra[i] = k == 0 && i == 0 ? {1'b1, 32'h10, 32'h11223344, 4'hF} : rnd_a();
          bus_a.m_req[i*RA +: RA] = ra[i];
        end
      serve_a(tbl[k].first, tbl[k].dly);
      if (tbl[k].n == 2) serve_a(tbl[k].second, tbl[k].dly);
    end
    reset_mid_busy();
`ifdef MERGE_TIMEOUT_EN
    timeout_test();
`endif
    random_a();
    test_b();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
